// File: rtl/d2e_pipe_reg_if.sv
// D->E pipeline register bus: decoded D-stage fields in, registered E-stage fields out.
// The hazard controls (stall/flush) travel with the D-side bundle.
interface d2e_pipe_reg_if #(
  parameter int DW = 32
);
  logic          stall;
  logic          flush;
  logic [DW-1:0] instr_D;
  logic [DW-1:0] pc_D;
  logic [DW-1:0] rd1_D;
  logic [DW-1:0] rd2_D;
  logic [DW-1:0] ext_D;
  logic [3:0]    alu_op_D;
  logic [2:0]    alub_sel_D;
  logic [2:0]    a3_sel_D;
  logic [2:0]    rd_sel_D;
  logic          reg_write_D;
  logic          mem_write_D;
  logic          lwso_D;
  logic [2:0]    tnew_D;

  logic [DW-1:0] instr_E;
  logic [DW-1:0] pc_E;
  logic [DW-1:0] rd1_E;
  logic [DW-1:0] rd2_E;
  logic [DW-1:0] ext_E;
  logic [3:0]    alu_op_E;
  logic [2:0]    alub_sel_E;
  logic [2:0]    rd_sel_E;
  logic          reg_write_E;
  logic          mem_write_E;
  logic          lwso_E;
  logic [4:0]    a3_E;
  logic [2:0]    tnew_E;
  logic          fwd_val_E;
  logic [DW-1:0] fwd_data_E;
  logic          valid_E;

  modport master (
    output stall, flush, instr_D, pc_D, rd1_D, rd2_D, ext_D, alu_op_D, alub_sel_D,
           a3_sel_D, rd_sel_D, reg_write_D, mem_write_D, lwso_D, tnew_D,
    input  instr_E, pc_E, rd1_E, rd2_E, ext_E, alu_op_E, alub_sel_E, rd_sel_E,
           reg_write_E, mem_write_E, lwso_E, a3_E, tnew_E, fwd_val_E, fwd_data_E, valid_E
  );

  modport slave (
    input  stall, flush, instr_D, pc_D, rd1_D, rd2_D, ext_D, alu_op_D, alub_sel_D,
           a3_sel_D, rd_sel_D, reg_write_D, mem_write_D, lwso_D, tnew_D,
    output instr_E, pc_E, rd1_E, rd2_E, ext_E, alu_op_E, alub_sel_E, rd_sel_E,
           reg_write_E, mem_write_E, lwso_E, a3_E, tnew_E, fwd_val_E, fwd_data_E, valid_E
  );
endinterface

// File: rtl/d2e_pipe_reg.sv
// D->E pipeline register: captures the decoded D-stage instruction, inserts bubbles on
// stall/flush, resolves the E-stage destination register and counts stall bubbles.
module d2e_pipe_reg #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  d2e_pipe_reg_if.slave    bus,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [4:0] a3_nxt;

  // Destination resolution; a $0 destination naturally collapses to "no write".
  always_comb begin
    a3_nxt = 5'd0;
    if (bus.reg_write_D) begin
      case (bus.a3_sel_D)
        3'd1:    a3_nxt = bus.instr_D[15:11];
        3'd2:    a3_nxt = bus.instr_D[20:16];
        3'd3:    a3_nxt = 5'd31;
        default: a3_nxt = 5'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush || bus.stall) begin
      bus.instr_E     <= '0;
      bus.pc_E        <= '0;
      bus.rd1_E       <= '0;
      bus.rd2_E       <= '0;
      bus.ext_E       <= '0;
      bus.alu_op_E    <= '0;
      bus.alub_sel_E  <= '0;
      bus.rd_sel_E    <= '0;
      bus.reg_write_E <= 1'b0;
      bus.mem_write_E <= 1'b0;
      bus.lwso_E      <= 1'b0;
      bus.a3_E        <= '0;
      bus.tnew_E      <= '0;
      bus.valid_E     <= 1'b0;
    end else begin
      bus.instr_E     <= bus.instr_D;
      bus.pc_E        <= bus.pc_D;
      bus.rd1_E       <= bus.rd1_D;
      bus.rd2_E       <= bus.rd2_D;
      bus.ext_E       <= bus.ext_D;
      bus.alu_op_E    <= bus.alu_op_D;
      bus.alub_sel_E  <= bus.alub_sel_D;
      bus.rd_sel_E    <= bus.rd_sel_D;
      bus.reg_write_E <= bus.reg_write_D;
      bus.mem_write_E <= bus.mem_write_D;
      bus.lwso_E      <= bus.lwso_D;
      bus.a3_E        <= a3_nxt;
      bus.tnew_E      <= bus.tnew_D;
      bus.valid_E     <= 1'b1;
    end
  end

  // Flush-induced bubbles are not hazard stalls, so they are not counted.
  always_ff @(posedge clk) begin
    if (reset)
      bubble_cnt <= '0;
    else if (bus.stall && !bus.flush && bubble_cnt != CNT_MAX)
      bubble_cnt <= bubble_cnt + 1'b1;
  end

  assign bus.fwd_data_E = bus.pc_E + DW'(8);
  assign bus.fwd_val_E  = (bus.tnew_E == 3'd0) && (bus.a3_E != 5'd0) && bus.valid_E;

endmodule

// File: tb/tb_d2e_pipe_reg.sv
// Directed bench for d2e_pipe_reg: a reference model pushes expected E-stage state per edge
// into a queue, which is popped and compared one step after each rising edge.
module tb_d2e_pipe_reg;

  localparam int DW    = 32;
  localparam int CNT_W = 4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] ext;
    logic [3:0]  alu_op;
    logic [4:0]  a3;
    logic [2:0]  tnew;
    logic        rw;
    logic        mw;
    logic        valid;
    logic        fv;
    logic [31:0] fd;
    logic [3:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [CNT_W-1:0] bubble_cnt;

  d2e_pipe_reg_if #(.DW(DW)) bus ();

  d2e_pipe_reg #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;
  logic [3:0] m_cnt = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drives one D-stage step, predicts the E state after the next edge, then checks it.
  task automatic step(input logic rs, input logic st, input logic fl,
                      input logic [31:0] instr, input logic [31:0] pc,
                      input logic [2:0] a3sel, input logic [2:0] tnew,
                      input logic rw, input logic mw);
    exp_t e;
    exp_t o;
    logic [31:0] r1;
    logic [31:0] ex;
    r1 = $urandom;
    ex = $urandom;
    reset          = rs;
    bus.stall      = st;
    bus.flush      = fl;
    bus.instr_D    = instr;
    bus.pc_D       = pc;
    bus.rd1_D      = r1;
    bus.rd2_D      = ~r1;
    bus.ext_D      = ex;
    bus.alu_op_D   = instr[3:0];
    bus.alub_sel_D = 3'd1;
    bus.a3_sel_D   = a3sel;
    bus.rd_sel_D   = 3'd2;
    bus.reg_write_D = rw;
    bus.mem_write_D = mw;
    bus.lwso_D     = 1'b0;
    bus.tnew_D     = tnew;

    e = '{instr: 0, pc: 0, rd1: 0, ext: 0, alu_op: 0, a3: 0, tnew: 0,
          rw: 0, mw: 0, valid: 0, fv: 0, fd: 0, cnt: 0};
    if (rs) begin
      m_cnt = 4'd0;
    end else if (fl || st) begin
      if (st && !fl && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    end else begin
      e.instr = instr; e.pc = pc; e.rd1 = r1; e.ext = ex; e.alu_op = instr[3:0];
      e.tnew = tnew; e.rw = rw; e.mw = mw; e.valid = 1'b1;
      if (rw) begin
        if (a3sel == 3'd1)      e.a3 = instr[15:11];
        else if (a3sel == 3'd2) e.a3 = instr[20:16];
        else if (a3sel == 3'd3) e.a3 = 5'd31;
      end
    end
    e.cnt = m_cnt;
    e.fd  = e.pc + 32'd8;
    e.fv  = (e.tnew == 3'd0) && (e.a3 != 5'd0) && e.valid;
    q.push_back(e);

    @(posedge clk);
    #1;
    o = q.pop_front();
    chk("instr_E",     bus.instr_E,     o.instr);
    chk("pc_E",        bus.pc_E,        o.pc);
    chk("rd1_E",       bus.rd1_E,       o.rd1);
    chk("ext_E",       bus.ext_E,       o.ext);
    chk("alu_op_E",    32'(bus.alu_op_E), 32'(o.alu_op));
    chk("a3_E",        32'(bus.a3_E),   32'(o.a3));
    chk("tnew_E",      32'(bus.tnew_E), 32'(o.tnew));
    chk("reg_write_E", 32'(bus.reg_write_E), 32'(o.rw));
    chk("mem_write_E", 32'(bus.mem_write_E), 32'(o.mw));
    chk("valid_E",     32'(bus.valid_E), 32'(o.valid));
    chk("fwd_val_E",   32'(bus.fwd_val_E), 32'(o.fv));
    chk("fwd_data_E",  bus.fwd_data_E,  o.fd);
    chk("bubble_cnt",  32'(bubble_cnt), 32'(o.cnt));
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    @(posedge clk);
    #1;
    // reset for two cycles
    step(1, 0, 0, 32'h0, 32'h0, 3'd0, 3'd0, 0, 0);
    step(1, 0, 0, 32'h0, 32'h0, 3'd0, 3'd0, 0, 0);
    // addu $3,$1,$2
    step(0, 0, 0, 32'h0022_1821, 32'h0000_3000, 3'd1, 3'd1, 1, 0);
    // jal: link to $31, forwardable immediately
    step(0, 0, 0, 32'h0C00_0C10, 32'h0000_3004, 3'd3, 3'd0, 1, 0);
    // lw $5,0($4) stalled twice then captured
    step(0, 1, 0, 32'h8C85_0000, 32'h0000_3008, 3'd2, 3'd2, 1, 0);
    step(0, 1, 0, 32'h8C85_0000, 32'h0000_3008, 3'd2, 3'd2, 1, 0);
    step(0, 0, 0, 32'h8C85_0000, 32'h0000_3008, 3'd2, 3'd2, 1, 0);
    // sw with stall and flush together: bubble, counter unchanged
    step(0, 1, 1, 32'hAC85_0004, 32'h0000_300C, 3'd0, 3'd2, 0, 1);
    // flush alone
    step(0, 0, 1, 32'hAC85_0004, 32'h0000_300C, 3'd0, 3'd2, 0, 1);
    // sw captured: memory side effect visible
    step(0, 0, 0, 32'hAC85_0004, 32'h0000_300C, 3'd0, 3'd2, 0, 1);
    // long stall: counter saturates at 15
    for (int i = 0; i < 20; i++)
      step(0, 1, 0, 32'h0000_0000, 32'h0000_3010, 3'd1, 3'd1, 1, 0);
    // ori $0,$0,1: write to $0 is no write
    step(0, 0, 0, 32'h3400_0001, 32'h0000_3010, 3'd2, 3'd1, 1, 0);
    // reg_write low forces a3_E=0 even with a3_sel=$31
    step(0, 0, 0, 32'h0C00_0000, 32'h0000_3014, 3'd3, 3'd0, 0, 0);
    // invalid a3_sel gives no destination
    step(0, 0, 0, 32'h0022_1821, 32'h0000_3018, 3'd5, 3'd0, 1, 0);
    // pc wrap on link value
    step(0, 0, 0, 32'h0C00_0000, 32'hFFFF_FFFC, 3'd3, 3'd0, 1, 0);
    // reset, build count of 7 with a live instruction, then reset mid-stream
    step(1, 0, 0, 32'h0, 32'h0, 3'd0, 3'd0, 0, 0);
    for (int i = 0; i < 7; i++)
      step(0, 1, 0, 32'h0022_1821, 32'h0000_3020, 3'd1, 3'd1, 1, 0);
    step(0, 0, 0, 32'h0022_1821, 32'h0000_3020, 3'd1, 3'd1, 1, 0);
    step(1, 0, 0, 32'h0022_1821, 32'h0000_3024, 3'd1, 3'd1, 1, 0);
    step(0, 0, 0, 32'h0022_1821, 32'h0000_3028, 3'd1, 3'd1, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
